// File: rtl/conv1_bnn_engine.sv
// conv1_bnn_engine: binary-weight 5x5 convolution engine for the conv1 stage.
// A window of KSIZE pixels and NUM_K binary kernels are captured on a start
// strobe. Each kernel's +/-x dot product is reduced to one activation bit.
// The result is handed over with a valid/ready handshake, and `over` tells
// the loader that it may advance its window.
// Optional build macro: CONV1_THRESH_EN enables per-kernel signed thresholds
// (folded batch-norm). Without it the threshold is a constant 0.
// Datapath timing: each CALC cycle registers the KPC lane sums. The compare
// and write into out_bits happen on the following edge, so CALC lasts
// NUM_K/KPC+1 cycles and the adder tree is kept apart from the compare.
module conv1_bnn_engine #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 25,
    parameter int NUM_K  = 12,
    parameter int KPC    = 3,
    parameter int ACC_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [KSIZE*DATA_W-1:0]   win_flat,
    input  logic [NUM_K*KSIZE-1:0]    wgt_flat,
    input  logic [NUM_K*ACC_W-1:0]    thresh_flat,
    output logic [NUM_K-1:0]          out_bits,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      over,
    output logic                      busy,
    output logic                      start_drop
);

    localparam int NGRP  = NUM_K / KPC;
    localparam int CNT_W = $clog2(NGRP + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NGRP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [KSIZE*DATA_W-1:0]   win_cap;
    logic [NUM_K*KSIZE-1:0]    wgt_cap;
    logic [CNT_W-1:0]          calc_cnt;
    logic [CNT_W-1:0]          grp_sel;
    logic [DATA_W-1:0]         pix      [KSIZE];
    logic signed [ACC_W-1:0]   lane_sum [KPC];
    logic signed [ACC_W-1:0]   sum_pipe [KPC];
    logic signed [ACC_W-1:0]   thr      [NUM_K];
    logic [NUM_K-1:0]          bits_next;
    logic                      accept_start;

    // A new window is taken only from a truly idle engine (not in the over cycle)
    assign accept_start = start && (state == IDLE) && !over;
    assign busy         = (state != IDLE);

    // The extra CALC cycle (calc_cnt == NGRP) only drains the pipe, so any
    // in-range group may feed the lanes then; group 0 keeps the index legal.
    assign grp_sel = (calc_cnt < LAST_CNT) ? calc_cnt : '0;

    // Unpack the captured window into individual pixels
    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_pix
        assign pix[gi] = win_cap[gi*DATA_W +: DATA_W];
    end

    // One signed accumulator per lane: +x where the weight bit is 1, -x where it is 0
    for (genvar gi = 0; gi < KPC; gi++) begin : g_lane
        logic [KSIZE-1:0]        wsel;
        logic signed [ACC_W-1:0] acc;

        // Select this lane's kernel for the current group
        always_comb begin
            wsel = '0;
            for (int g = 0; g < NGRP; g++) begin
                if (grp_sel == CNT_W'(g)) begin
                    wsel = wgt_cap[(g*KPC+gi)*KSIZE +: KSIZE];
                end
            end
        end

        // Signed dot product over all taps with zero-extended pixels
        always_comb begin
            acc = '0;
            for (int i = 0; i < KSIZE; i++) begin
                if (wsel[i]) begin
                    acc = acc + $signed({{(ACC_W-DATA_W){1'b0}}, pix[i]});
                end else begin
                    acc = acc - $signed({{(ACC_W-DATA_W){1'b0}}, pix[i]});
                end
            end
        end

        assign lane_sum[gi] = acc;
    end

`ifdef CONV1_THRESH_EN
    logic [NUM_K*ACC_W-1:0] thresh_cap;

    // Thresholds are captured with the window so they match the data being processed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_cap <= '0;
        end else if (accept_start) begin
            thresh_cap <= thresh_flat;
        end
    end

    for (genvar gi = 0; gi < NUM_K; gi++) begin : g_thr
        assign thr[gi] = $signed(thresh_cap[gi*ACC_W +: ACC_W]);
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_flat;

    for (genvar gi = 0; gi < NUM_K; gi++) begin : g_thr
        assign thr[gi] = '0;
    end
`endif

    // Binarise the group whose sums sit in the pipe (calc_cnt is one ahead of it)
    for (genvar gi = 0; gi < NUM_K; gi++) begin : g_bit
        localparam int G = gi / KPC;
        localparam int L = gi % KPC;
        assign bits_next[gi] = (calc_cnt == CNT_W'(G + 1)) ? (sum_pipe[L] >= thr[gi])
                                                           : out_bits[gi];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> CALC -> HOLD -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_start)         state_next = CALC;
            CALC: if (calc_cnt == LAST_CNT) state_next = HOLD;
            HOLD: if (out_ready)            state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Capture, group sequencing, result register and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cap    <= '0;
            wgt_cap    <= '0;
            calc_cnt   <= '0;
            out_bits   <= '0;
            out_valid  <= 1'b0;
            over       <= 1'b0;
            start_drop <= 1'b0;
            for (int j = 0; j < KPC; j++) begin
                sum_pipe[j] <= '0;
            end
        end else begin
            over <= 1'b0;
            if (start && !accept_start) begin
                start_drop <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        win_cap  <= win_flat;
                        wgt_cap  <= wgt_flat;
                        calc_cnt <= '0;
                    end
                end
                CALC: begin
                    out_bits <= bits_next;
                    if (calc_cnt != LAST_CNT) begin
                        for (int j = 0; j < KPC; j++) begin
                            sum_pipe[j] <= lane_sum[j];
                        end
                        calc_cnt <= calc_cnt + CNT_W'(1);
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        over      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_bnn_engine.sv
// Self-checking bench for conv1_bnn_engine: an arithmetic model of the
// dot-product/binarise rule plus a start-to-valid countdown, compared with
// the DUT every cycle, and hand-computed literal expectations per window.
module tb_conv1_bnn_engine;

    localparam int DATA_W = 8;
    localparam int KSIZE  = 25;
    localparam int NUM_K  = 12;
    localparam int KPC    = 3;
    localparam int ACC_W  = 14;
    localparam int NGRP   = NUM_K / KPC;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic [KSIZE*DATA_W-1:0]  win_flat;
    logic [NUM_K*KSIZE-1:0]   wgt_flat;
    logic [NUM_K*ACC_W-1:0]   thresh_flat;
    logic [NUM_K-1:0]         out_bits;
    logic                     out_valid;
    logic                     out_ready;
    logic                     over;
    logic                     busy;
    logic                     start_drop;

    int n_checks = 0;
    int n_fail   = 0;

    conv1_bnn_engine #(
        .DATA_W(DATA_W), .KSIZE(KSIZE), .NUM_K(NUM_K), .KPC(KPC), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .win_flat(win_flat), .wgt_flat(wgt_flat), .thresh_flat(thresh_flat),
        .out_bits(out_bits), .out_valid(out_valid), .out_ready(out_ready),
        .over(over), .busy(busy), .start_drop(start_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: sum of +x/-x per kernel, bit = sum >= threshold
    function automatic logic [NUM_K-1:0] model_bits(input logic [KSIZE*DATA_W-1:0] w,
                                                    input logic [NUM_K*KSIZE-1:0] k,
                                                    input logic [NUM_K*ACC_W-1:0] t);
        logic [NUM_K-1:0] r;
        logic signed [ACC_W-1:0] th_v;
        int s;
        int th;
        r = '0;
        for (int kk = 0; kk < NUM_K; kk++) begin
            s = 0;
            for (int i = 0; i < KSIZE; i++) begin
                if (k[kk*KSIZE+i]) s = s + int'(w[i*DATA_W +: DATA_W]);
                else               s = s - int'(w[i*DATA_W +: DATA_W]);
            end
            th_v = t[kk*ACC_W +: ACC_W];
`ifdef CONV1_THRESH_EN
            th = int'(th_v);
`else
            th = 0;
            if (th_v == th_v) th = 0;
`endif
            r[kk] = (s >= th);
        end
        return r;
    endfunction

    // Timing model: start from an idle engine -> result valid NGRP+1 edges later;
    // accept -> over for one cycle; start while occupied -> sticky drop flag.
    int               m_pend;
    logic             m_valid, m_over, m_drop, m_acc, m_occ;
    logic [NUM_K-1:0] m_bits, m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_drop  = 1'b0;
            m_bits  = '0;
            m_res   = '0;
        end else begin
            m_acc = m_valid && out_ready;
            m_occ = (m_pend != 0) || m_valid || m_over;
            if (start && m_occ) m_drop = 1'b1;
            if (m_pend != 0) begin
                m_pend = m_pend - 1;
                if (m_pend == 0) begin
                    m_valid = 1'b1;
                    m_bits  = m_res;
                end
            end else if (start && !m_occ) begin
                m_res  = model_bits(win_flat, wgt_flat, thresh_flat);
                m_pend = NGRP + 1;
            end
            if (m_acc) m_valid = 1'b0;
            m_over = m_acc;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("over", 32'(over), 32'(m_over));
        check("busy", 32'(busy), 32'((m_pend != 0) || m_valid));
        check("start_drop", 32'(start_drop), 32'(m_drop));
        if (m_pend == 0) check("out_bits", 32'(out_bits), 32'(m_bits));
    end

    function automatic logic [KSIZE*DATA_W-1:0] fill_win(input logic [DATA_W-1:0] v);
        logic [KSIZE*DATA_W-1:0] r;
        for (int i = 0; i < KSIZE; i++) r[i*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    function automatic logic [NUM_K*KSIZE-1:0] odd_kernels_ones();
        logic [NUM_K*KSIZE-1:0] r;
        for (int kk = 0; kk < NUM_K; kk++) r[kk*KSIZE +: KSIZE] = (kk % 2 == 1) ? '1 : '0;
        return r;
    endfunction

    function automatic logic [NUM_K*ACC_W-1:0] split_thresh(input int lo, input int hi);
        logic [NUM_K*ACC_W-1:0] r;
        for (int kk = 0; kk < NUM_K; kk++) r[kk*ACC_W +: ACC_W] = (kk < 6) ? ACC_W'(lo) : ACC_W'(hi);
        return r;
    endfunction

    // One transaction: strobe start, scramble inputs (only the captured copy may matter),
    // wait for out_valid with a bound, check latency/result and the over pulse.
    task automatic run_window(input string name,
                              input logic [KSIZE*DATA_W-1:0] w,
                              input logic [NUM_K*KSIZE-1:0] k,
                              input logic [NUM_K*ACC_W-1:0] t,
                              input logic [NUM_K-1:0] lit);
        int lat;
        check({name, "_model"}, 32'(model_bits(w, k, t)), 32'(lit));
        win_flat    = w;
        wgt_flat    = k;
        thresh_flat = t;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        win_flat = ~w;
        wgt_flat = ~k;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd5);
        check({name, "_bits"}, 32'(out_bits), 32'(lit));
        $display("window %s: out_bits=%h latency=%0d", name, out_bits, lat);
        if (out_ready) begin
            @(negedge clk);
            check({name, "_over_pulse"}, 32'(over), 32'd1);
            check({name, "_valid_cleared"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            check({name, "_over_end"}, 32'(over), 32'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b1;
        win_flat    = '0;
        wgt_flat    = '0;
        thresh_flat = '0;
        repeat (3) @(negedge clk);
        check("reset_bits", 32'(out_bits), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop", 32'(start_drop), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_window("ones_pos", fill_win(8'd10), '1, '0, 12'hFFF);
        run_window("ones_neg", fill_win(8'd10), '0, '0, 12'h000);
        run_window("zero_win", fill_win(8'd0), odd_kernels_ones(), '0, 12'hFFF);
        run_window("max_alt", fill_win(8'd255), odd_kernels_ones(), '0, 12'hAAA);
`ifdef CONV1_THRESH_EN
        run_window("thresh", fill_win(8'd10), '1, split_thresh(250, 251), 12'h03F);
`endif

        // Back-pressure: result held, start during hold dropped
        out_ready = 1'b0;
        run_window("hold", fill_win(8'd255), odd_kernels_ones(), '0, 12'hAAA);
        repeat (4) @(negedge clk);
        win_flat = fill_win(8'd10);
        wgt_flat = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_drop", 32'(start_drop), 32'd1);
        repeat (5) @(negedge clk);
        check("hold_bits", 32'(out_bits), 32'h0AAA);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_no_over", 32'(over), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_over", 32'(over), 32'd1);
        repeat (2) @(negedge clk);

        // Reset during CALC group 2: outputs clear at once, no over afterwards
        win_flat = fill_win(8'd10);
        wgt_flat = '1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_bits", 32'(out_bits), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_over", 32'(over), 32'd0);
        check("abort_drop", 32'(start_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_window("after_reset", fill_win(8'd10), '0, '0, 12'h000);
        run_window("after_reset2", fill_win(8'd10), '1, '0, 12'hFFF);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
